wb_arbiter: RTL and testbench

Write-back arbiter directly upstream of `Register_File` write port 3. Merges two result sources into the single `WriteEnable3`/`Address3`/`WD3` port: the zero-latency single-cycle core path (ALU/load result) and a valid/ready long-latency path (iterative mul/div), which is buffered in a small FIFO. It drains buffered results in cycles where the core does not write. If a buffered result waits too long, it requests a one-cycle core stall to guarantee progress.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/wb_fifo.sv | 64 ++++++
 rtl/wb_arbiter.sv | 114 +++++++++++
 tb/tb_wb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core types for the write-back path: register-file geometry and the
// buffered result entry that travels from the long-latency units to write port 3.
// No logic; types and constants only.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small result FIFO for long-latency write-back entries (DEPTH power of two).
// Latency: a pushed entry becomes head the cycle after the push edge, no fall-through.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
// Ports: clk, rst (async active-low), push/din, pop, head, full, empty, count.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              din,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset: entries are only observed through count/empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for register-file port 3: core path has priority, long-path results buffered.
// Latency: core path 0 cycles (combinational); long path >= 1 cycle from accept to WriteEnable3.
// Backpressure: lr_ready = !full (registered count); stall_req after STARVE_LIMIT starved head cycles.
// Ports: clk, rst (async active-low), core_we/rd/wd, lr_valid/ready/rd/wd, WriteEnable3/Address3/WD3,
//        stall_req, fifo_count. Optional macro WB_FORWARD_EN adds fwd_a1/a2, rf_rd1/2 in, fwd_rd1/2 out.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_we,
    input  logic [REG_AW-1:0]      core_rd,
    input  logic [XLEN-1:0]        core_wd,
    input  logic                   lr_valid,
    output logic                   lr_ready,
    input  logic [REG_AW-1:0]      lr_rd,
    input  logic [XLEN-1:0]        lr_wd,
    output logic                   WriteEnable3,
    output logic [REG_AW-1:0]      Address3,
    output logic [XLEN-1:0]        WD3,
    output logic                   stall_req,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef WB_FORWARD_EN
    ,
    input  logic [REG_AW-1:0]      fwd_a1,
    input  logic [REG_AW-1:0]      fwd_a2,
    input  logic [XLEN-1:0]        rf_rd1,
    input  logic [XLEN-1:0]        rf_rd2,
    output logic [XLEN-1:0]        fwd_rd1,
    output logic [XLEN-1:0]        fwd_rd2
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    wb_entry_t     lr_entry;
    wb_entry_t     fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          core_slot;
    logic [SW-1:0] starve_cnt;

    // A write to x0 frees the slot: it is architecturally a no-op.
    assign core_slot = core_we && (core_rd != '0);

    assign lr_entry.rd = lr_rd;
    assign lr_entry.wd = lr_wd;

    // Ready depends only on registered occupancy, never on lr_valid.
    assign lr_ready  = rst && !fifo_full;
    // x0 results are acknowledged but never buffered.
    assign fifo_push = lr_valid && lr_ready && (lr_rd != '0);
    assign fifo_pop  = rst && !core_slot && !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (lr_entry),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Port 3 mux; everything is forced low while reset is asserted so an
    // in-flight reset can never produce a partial write.
    always_comb begin
        WriteEnable3 = 1'b0;
        Address3     = '0;
        WD3          = '0;
        if (rst) begin
            if (core_slot) begin
                WriteEnable3 = 1'b1;
                Address3     = core_rd;
                WD3          = core_wd;
            end else if (!fifo_empty) begin
                WriteEnable3 = 1'b1;
                Address3     = fifo_head.rd;
                WD3          = fifo_head.wd;
            end
        end
    end

    // Counts cycles the head has been blocked. Saturates at LIMIT so a core that
    // ignores stall_req cannot wrap the counter and silently drop the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign stall_req = (starve_cnt >= LIMIT);

`ifdef WB_FORWARD_EN
    // Same-cycle bypass of the value being written this cycle.
    assign fwd_rd1 = (WriteEnable3 && (Address3 == fwd_a1) && (fwd_a1 != '0)) ? WD3 : rf_rd1;
    assign fwd_rd2 = (WriteEnable3 && (Address3 == fwd_a2) && (fwd_a2 != '0)) ? WD3 : rf_rd2;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
// Latency: n/a (testbench).
// Backpressure: honours lr hold rule and the stall_req core contract when generating traffic.
module tb_wb_arbiter;
    import riscv_pkg::*;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   core_we;
    logic [4:0]             core_rd;
    logic [31:0]            core_wd;
    logic                   lr_valid;
    logic                   lr_ready;
    logic [4:0]             lr_rd;
    logic [31:0]            lr_wd;
    logic                   WriteEnable3;
    logic [4:0]             Address3;
    logic [31:0]            WD3;
    logic                   stall_req;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef WB_FORWARD_EN
    logic [4:0]             fwd_a1, fwd_a2;
    logic [31:0]            rf_rd1, rf_rd2, fwd_rd1, fwd_rd2;
`endif

    wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_we      (core_we),
        .core_rd      (core_rd),
        .core_wd      (core_wd),
        .lr_valid     (lr_valid),
        .lr_ready     (lr_ready),
        .lr_rd        (lr_rd),
        .lr_wd        (lr_wd),
        .WriteEnable3 (WriteEnable3),
        .Address3     (Address3),
        .WD3          (WD3),
        .stall_req    (stall_req),
        .fifo_count   (fifo_count)
`ifdef WB_FORWARD_EN
        ,
        .fwd_a1       (fwd_a1),
        .fwd_a2       (fwd_a2),
        .rf_rd1       (rf_rd1),
        .rf_rd2       (rf_rd2),
        .fwd_rd1      (fwd_rd1),
        .fwd_rd2      (fwd_rd2)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file consumer fed by port 3.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (WriteEnable3) rf[Address3] <= WD3;
    end

    // Reference model: pending long-path results in arrival order and how long
    // the oldest has been kept waiting.
    wb_entry_t mq[$];
    int        mwait = 0;

    always @(posedge clk or negedge rst) begin : model_upd
        bit        m_pop;
        bit        m_push;
        wb_entry_t e;
        if (!rst) begin
            mq.delete();
            mwait = 0;
        end else begin
            m_pop  = !(core_we && core_rd != 5'd0) && (mq.size() > 0);
            m_push = lr_valid && (mq.size() < DEPTH) && (lr_rd != 5'd0);
            if (mq.size() > 0 && !m_pop) mwait++;
            else                         mwait = 0;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                e.rd = lr_rd;
                e.wd = lr_wd;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : model_cmp
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        e_we = 1'b0;
        e_a  = 5'd0;
        e_d  = 32'd0;
        if (rst) begin
            if (core_we && core_rd != 5'd0) begin
                e_we = 1'b1; e_a = core_rd; e_d = core_wd;
            end else if (mq.size() > 0) begin
                e_we = 1'b1; e_a = mq[0].rd; e_d = mq[0].wd;
            end
        end
        chk("model_we",    32'(WriteEnable3), 32'(e_we));
        chk("model_addr",  32'(Address3),     32'(e_a));
        chk("model_wd",    WD3,               e_d);
        chk("model_ready", 32'(lr_ready),     32'(rst && (mq.size() < DEPTH)));
        chk("model_stall", 32'(stall_req),    32'(mwait >= STARVE_LIMIT));
        chk("model_count", 32'(fifo_count),   32'(mq.size()));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst = 1'b0; core_we = 1'b1; core_rd = 5'd5; core_wd = 32'h12345678;
        lr_valid = 1'b0; lr_rd = 5'd0; lr_wd = 32'd0;
`ifdef WB_FORWARD_EN
        fwd_a1 = 5'd0; fwd_a2 = 5'd0; rf_rd1 = 32'd0; rf_rd2 = 32'd0;
`endif
        // Reset behaviour
        tick(); tick();
        chk("rst_we",    32'(WriteEnable3), 32'd0);
        chk("rst_addr",  32'(Address3),     32'd0);
        chk("rst_ready", 32'(lr_ready),     32'd0);
        chk("rst_stall", 32'(stall_req),    32'd0);
        chk("rst_count", 32'(fifo_count),   32'd0);
        rst = 1'b1; #1;
        chk("rel_we",    32'(WriteEnable3), 32'd1);
        chk("rel_addr",  32'(Address3),     32'd5);
        chk("rel_wd",    WD3,               32'h12345678);
        chk("rel_ready", 32'(lr_ready),     32'd1);
        tick();
        chk("rf_x5",     rf[5],             32'h12345678);

        // Push into empty FIFO with core idle: no fall-through, head next cycle
        core_we = 1'b0; lr_valid = 1'b1; lr_rd = 5'd7; lr_wd = 32'hDEADBEEF; #1;
        chk("nofall_we", 32'(WriteEnable3), 32'd0);
        tick();
        lr_valid = 1'b0; #1;
        chk("drain_we",    32'(WriteEnable3), 32'd1);
        chk("drain_addr",  32'(Address3),     32'd7);
        chk("drain_wd",    WD3,               32'hDEADBEEF);
        chk("drain_cnt1",  32'(fifo_count),   32'd1);
        tick();
        chk("drain_cnt0",  32'(fifo_count),   32'd0);
        chk("rf_x7",       rf[7],             32'hDEADBEEF);

        // Fill FIFO while core keeps the port busy
        core_we = 1'b1; core_rd = 5'd3; core_wd = 32'h000000A0;
        lr_valid = 1'b1; lr_rd = 5'd10; lr_wd = 32'h00001010;
        tick();
        lr_rd = 5'd11; lr_wd = 32'h00001111;
        tick();
        lr_rd = 5'd12; lr_wd = 32'h00001212; #1;
        chk("full_cnt",   32'(fifo_count), 32'd2);
        chk("full_ready", 32'(lr_ready),   32'd0);
        chk("full_core",  32'(Address3),   32'd3);
        tick(); tick();
        chk("hold_cnt",   32'(fifo_count), 32'd2);
        core_we = 1'b0; #1;
        chk("full_drain_addr", 32'(Address3), 32'd10);
        chk("full_drain_wd",   WD3,           32'h00001010);
        tick();
        chk("pp_ready", 32'(lr_ready), 32'd1);
        chk("pp_addr",  32'(Address3), 32'd11);
        tick();
        lr_valid = 1'b0; #1;
        chk("pp_cnt",   32'(fifo_count), 32'd1);
        chk("held_addr", 32'(Address3),  32'd12);
        chk("held_wd",   WD3,            32'h00001212);
        tick();
        chk("empty_cnt", 32'(fifo_count), 32'd0);

        // Starvation: head blocked by continuous core writes
        core_we = 1'b1; core_rd = 5'd3; core_wd = 32'h00000033;
        lr_valid = 1'b1; lr_rd = 5'd20; lr_wd = 32'h00002020;
        tick();
        lr_valid = 1'b0; #1;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            chk("starve_low", 32'(stall_req), 32'd0);
            tick();
        end
        chk("starve_high", 32'(stall_req), 32'd1);
        core_we = 1'b0; #1;
        chk("starve_addr", 32'(Address3), 32'd20);
        chk("starve_wd",   WD3,           32'h00002020);
        tick();
        chk("starve_clr",  32'(stall_req),  32'd0);
        chk("starve_cnt",  32'(fifo_count), 32'd0);

        // x0 rules
        core_we = 1'b1; core_rd = 5'd3;
        lr_valid = 1'b1; lr_rd = 5'd21; lr_wd = 32'h00002121;
        tick();
        lr_valid = 1'b0; core_rd = 5'd0; core_wd = 32'h00000BAD; #1;
        chk("x0_drain_we",   32'(WriteEnable3), 32'd1);
        chk("x0_drain_addr", 32'(Address3),     32'd21);
        tick();
        chk("x0_core_we",    32'(WriteEnable3), 32'd0);
        lr_valid = 1'b1; lr_rd = 5'd0; lr_wd = 32'h00000999; #1;
        chk("x0_lr_ready",   32'(lr_ready),     32'd1);
        tick();
        lr_valid = 1'b0; #1;
        chk("x0_lr_cnt",     32'(fifo_count),   32'd0);
        chk("x0_lr_we",      32'(WriteEnable3), 32'd0);

`ifdef WB_FORWARD_EN
        core_we = 1'b1; core_rd = 5'd9; core_wd = 32'hCAFEF00D;
        fwd_a1 = 5'd9; rf_rd1 = 32'd0; fwd_a2 = 5'd4; rf_rd2 = 32'h00000044; #1;
        chk("fwd1_hit",  fwd_rd1, 32'hCAFEF00D);
        chk("fwd2_miss", fwd_rd2, 32'h00000044);
        fwd_a1 = 5'd0; rf_rd1 = 32'h00000055; #1;
        chk("fwd1_x0",   fwd_rd1, 32'h00000055);
        fwd_a1 = 5'd0; fwd_a2 = 5'd0;
`endif

        // Mixed traffic, checked by the model every cycle
        acc = 1'b0;
        for (int i = 0; i < 48; i++) begin
            core_we = stall_req ? 1'b0 : ((i % 4) != 3);
            core_rd = 5'(i % 5);
            core_wd = 32'h00001000 + 32'(i);
            if (!(lr_valid && !acc)) begin
                lr_valid = ((i % 3) != 1);
                lr_rd    = 5'((i * 7) % 32);
                lr_wd    = 32'h0000A000 + 32'(i);
            end
            #1;
            acc = lr_valid && lr_ready;
            tick();
        end

        // Reset mid-operation drops buffered entries
        lr_valid = 1'b0; core_we = 1'b1; core_rd = 5'd3;
        tick(); tick(); tick();
        lr_valid = 1'b1; lr_rd = 5'd14; lr_wd = 32'h00001414;
        tick();
        lr_rd = 5'd15; lr_wd = 32'h00001515;
        tick();
        lr_valid = 1'b0; #1;
        chk("mid_cnt2", 32'(fifo_count), 32'd2);
        rst = 1'b0; #1;
        chk("mid_we",    32'(WriteEnable3), 32'd0);
        chk("mid_cnt0",  32'(fifo_count),   32'd0);
        chk("mid_ready", 32'(lr_ready),     32'd0);
        tick();
        rst = 1'b1; core_we = 1'b0; #1;
        chk("post_we",    32'(WriteEnable3), 32'd0);
        chk("post_cnt",   32'(fifo_count),   32'd0);
        chk("post_ready", 32'(lr_ready),     32'd1);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
